// File: rtl/vote_link_arbiter.sv
// Round-robin arbiter sharing one 4-bit vote link between N_ST stations.
// Parity-screens each vote and runs the rtr/cts four-phase handshake with a timeout abort.
module vote_link_arbiter #(
    parameter int unsigned N_ST    = 4,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned IDW     = (N_ST > 1) ? $clog2(N_ST) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_ST-1:0]   req,
    input  logic [4*N_ST-1:0] v_in,
    output logic [N_ST-1:0]   ack,
    output logic [N_ST-1:0]   nack,
    input  logic              rtr,
    output logic              cts,
    output logic [3:0]        v_out,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned    TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  TmoMax = TW'(TIMEOUT);
    localparam logic [IDW-1:0] LastSt = IDW'(N_ST - 1);
    localparam logic [IDW:0]   NumSt  = (IDW + 1)'(N_ST);

    typedef enum logic [1:0] {StIdle, StWaitRtr, StWaitRel} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      hold_q, hold_d;
    logic [3:0]      v_out_q, v_out_d;
    logic            cts_q, cts_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [N_ST-1:0] ack_q, ack_d;
    logic [N_ST-1:0] nack_q, nack_d;

    logic [N_ST-1:0] elig;
    logic [IDW:0]    sum;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  win;
    logic [3:0]      win_vote;
    logic            found;
    logic            tmo_hit;
    logic            abort;

    // First eligible station at or after rr_ptr; stations pulsed this cycle sit out.
    always_comb begin
        elig     = req & ~ack_q & ~nack_q;
        found    = 1'b0;
        win      = '0;
        sum      = '0;
        cand     = '0;
        win_vote = '0;
        for (int k = 0; k < int'(N_ST); k++) begin
            sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            if (sum >= NumSt) begin
                sum = sum - NumSt;
            end
            cand = sum[IDW-1:0];
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        for (int j = 0; j < int'(N_ST); j++) begin
            if (win == IDW'(j)) begin
                win_vote = v_in[4*j +: 4];
            end
        end
    end

    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TmoMax);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        tmo_d    = tmo_q;
        hold_d   = hold_q;
        v_out_d  = v_out_q;
        cts_d    = cts_q;
        busy_d   = busy_q;
        err_d    = err_q;
        ack_d    = '0;
        nack_d   = '0;
        abort    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    rr_ptr_d = (win == LastSt) ? '0 : win + 1'b1;
                    if (win_vote[3] != ^win_vote[2:0]) begin
                        nack_d[win] = 1'b1;
                    end else begin
                        hold_d  = win_vote;
                        grant_d = win;
                        tmo_d   = '0;
                        busy_d  = 1'b1;
                        state_d = StWaitRtr;
                    end
                end
            end
            StWaitRtr: begin
                if (rtr) begin
                    v_out_d = hold_q;
                    cts_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = StWaitRel;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitRel: begin
                if (!rtr) begin
                    cts_d          = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    busy_d         = 1'b0;
                    state_d        = StIdle;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            cts_d           = 1'b0;
            nack_d[grant_q] = 1'b1;
            err_d           = 1'b1;
            busy_d          = 1'b0;
            state_d         = StIdle;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            tmo_q    <= '0;
            hold_q   <= '0;
            v_out_q  <= '0;
            cts_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            ack_q    <= '0;
            nack_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            tmo_q    <= tmo_d;
            hold_q   <= hold_d;
            v_out_q  <= v_out_d;
            cts_q    <= cts_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
        end
    end

    assign ack         = ack_q;
    assign nack        = nack_q;
    assign cts         = cts_q;
    assign v_out       = v_out_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_vote_link_arbiter.sv
// Bench for vote_link_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_vote_link_arbiter;

    localparam int N   = 4;
    localparam int TMO = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] v_in;
    logic [3:0]  ack;
    logic [3:0]  nack;
    logic        rtr;
    logic        cts;
    logic [3:0]  v_out;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 waiting for rtr high, 2 waiting for rtr low.
    int         m_phase;
    int         m_ptr;
    int         m_wait;
    logic [3:0] m_hold;
    logic [3:0] m_vout;
    logic [3:0] m_ack;
    logic [3:0] m_nack;
    logic [1:0] m_gid;
    logic       m_cts;
    logic       m_busy;
    logic       m_err;

    vote_link_arbiter #(
        .N_ST    (N),
        .TIMEOUT (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .v_in        (v_in),
        .ack         (ack),
        .nack        (nack),
        .rtr         (rtr),
        .cts         (cts),
        .v_out       (v_out),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] make_vote(input logic [2:0] b, input logic good);
        return {(^b) ^ !good, b};
    endfunction

    function automatic logic [3:0] rand_vote();
        return make_vote(3'($urandom_range(0, 7)), $urandom_range(0, 99) < 85);
    endfunction

    // Runs the tally side until the link is idle again; req must already be low.
    task automatic drain();
        for (int i = 0; i < 60 && (busy || cts); i++) begin
            rtr = busy && !cts;
            tick();
        end
        rtr = 1'b0;
        tick();
    endtask

    // Advance the model by one clock edge using the inputs the DUT is about to sample.
    task automatic model_edge();
        logic [3:0] elig;
        logic [3:0] v;
        int         w;
        elig   = req & ~m_ack & ~m_nack;
        m_ack  = '0;
        m_nack = '0;
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_wait = 0; m_hold = '0; m_vout = '0;
            m_gid = '0; m_cts = 0; m_busy = 0; m_err = 0;
            return;
        end
        case (m_phase)
            0: begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                if (w >= 0) begin
                    v     = v_in[4*w +: 4];
                    m_ptr = (w + 1) % N;
                    if (v[3] != (v[0] ^ v[1] ^ v[2])) begin
                        m_nack[w] = 1'b1;
                    end else begin
                        m_hold = v; m_gid = 2'(w); m_busy = 1; m_wait = 0; m_phase = 1;
                    end
                end
            end
            default: begin
                if ((m_phase == 1) == (rtr == 1'b1)) begin
                    if (m_phase == 1) begin
                        m_vout = m_hold; m_cts = 1; m_wait = 0; m_phase = 2;
                    end else begin
                        m_cts = 0; m_ack[m_gid] = 1'b1; m_busy = 0; m_phase = 0;
                    end
                end else if (m_wait >= TMO) begin
                    m_cts = 0; m_nack[m_gid] = 1'b1; m_err = 1; m_busy = 0; m_phase = 0;
                end else begin
                    m_wait++;
                end
            end
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'hF; v_in = 16'hFFFF; rtr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ack, nack, cts, v_out, grant_id, busy, timeout_err} !== 17'h0) begin
                errors++;
                $display("FAIL reset cycle %0d: outputs %h, want 0", i,
                         {ack, nack, cts, v_out, grant_id, busy, timeout_err});
            end
        end
        reset = 1'b0; req = '0; rtr = 1'b0; v_in = '0;
        tick();
    endtask

    task automatic test_single();
        v_in[11:8] = 4'b0110; req = 4'b0100; rtr = 1'b0;
        tick();
        checks++;
        if ({busy, grant_id, cts} !== {1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL single grant: busy/id/cts %b, want 1_10_0", {busy, grant_id, cts});
        end
        tick(); tick();
        checks++;
        if (cts !== 1'b0) begin
            errors++; $display("FAIL single cts early: got %b want 0", cts);
        end
        rtr = 1'b1;
        tick();
        checks++;
        if ({cts, v_out} !== {1'b1, 4'b0110}) begin
            errors++; $display("FAIL single cts rise: cts/v_out %b, want 1_0110", {cts, v_out});
        end
        tick();
        checks++;
        if (cts !== 1'b1) begin
            errors++; $display("FAIL single cts second cycle: got %b want 1", cts);
        end
        rtr = 1'b0;
        tick();
        checks++;
        if ({cts, ack, nack, busy, v_out} !== {1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0110}) begin
            errors++;
            $display("FAIL single ack: cts/ack/nack/busy/v_out %b, want 0_0100_0000_0_0110",
                     {cts, ack, nack, busy, v_out});
        end
        req = '0;
        tick();
        checks++;
        if (ack !== 4'b0000) begin
            errors++; $display("FAIL single ack width: got %b want 0000", ack);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order[$];
        logic       prev_busy;
        int         cyc;
        bit         got;
        reset = 1'b1; req = '0; rtr = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) v_in[4*i +: 4] = make_vote(3'(i + 1), 1'b1);
        req = 4'hF; prev_busy = 1'b0; cyc = 0;
        while (order.size() < 5 && cyc < 100) begin
            tick();
            cyc++;
            if (busy && !prev_busy) order.push_back(grant_id);
            if (ack != 4'b0000) begin
                checks++;
                if (ack !== 4'(1 << ((order.size() - 1) % N))) begin
                    errors++;
                    $display("FAIL rr ack: got %b want %b", ack,
                             4'(1 << ((order.size() - 1) % N)));
                end
            end
            prev_busy = busy;
            rtr = busy && !cts;
        end
        checks++;
        if (order.size() != 5) begin
            errors++; $display("FAIL rr grant count: got %0d want 5", order.size());
        end
        for (int k = 0; k < order.size(); k++) begin
            checks++;
            if (order[k] !== 2'(k % N)) begin
                errors++; $display("FAIL rr order[%0d]: got %0d want %0d", k, order[k], k % N);
            end
        end
        // Only station 0 keeps requesting: it must sit out the cycle its ack is visible.
        req = 4'b0001; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (ack == 4'b0001) got = 1'b1;
            rtr = busy && !cts;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL rr skip ack: got %b want 0001", ack);
        end
        rtr = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rr skip pulsed: busy %b want 0", busy);
        end
        tick();
        checks++;
        if ({busy, grant_id} !== {1'b1, 2'd0}) begin
            errors++; $display("FAIL rr regrant: busy/id %b want 1_00", {busy, grant_id});
        end
        req = '0;
        drain();
    endtask

    task automatic test_parity();
        reset = 1'b1; req = '0; rtr = 1'b0;
        tick();
        reset = 1'b0;
        v_in[3:0] = 4'b1011; req = 4'b0001;
        tick();
        checks++;
        if ({nack, ack, busy, cts} !== {4'b0001, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL parity nack: nack/ack/busy/cts %b want 0001_0000_0_0",
                     {nack, ack, busy, cts});
        end
        req = '0;
        tick();
        checks++;
        if ({nack, cts} !== 5'b0) begin
            errors++; $display("FAIL parity after: nack/cts %b want 0", {nack, cts});
        end
        for (int i = 0; i < N; i++) v_in[4*i +: 4] = make_vote(3'(5 + i), 1'b1);
        req = 4'hF;
        tick();
        checks++;
        if ({busy, grant_id} !== {1'b1, 2'd1}) begin
            errors++; $display("FAIL parity ptr: busy/id %b want 1_01", {busy, grant_id});
        end
        req = '0;
        drain();
    endtask

    task automatic test_timeout();
        bit ok;
        bit got;
        v_in[11:8] = make_vote(3'b101, 1'b1); req = 4'b0100; rtr = 1'b0;
        tick();
        checks++;
        if ({busy, grant_id} !== {1'b1, 2'd2}) begin
            errors++; $display("FAIL tmo grant: busy/id %b want 1_10", {busy, grant_id});
        end
        ok = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            tick();
            if (!(busy === 1'b1 && nack === 4'b0 && cts === 1'b0)) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tmo early abort: busy/nack %b want 1_0000", {busy, nack});
        end
        tick();
        checks++;
        if ({nack, busy, timeout_err, cts} !== {4'b0100, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL tmo abort: nack/busy/err/cts %b want 0100_0_1_0",
                     {nack, busy, timeout_err, cts});
        end
        req = '0;
        tick();
        v_in[7:4] = make_vote(3'b110, 1'b1); req = 4'b0010; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (ack != 4'b0 || nack != 4'b0) got = 1'b1;
            rtr = busy && !cts;
        end
        checks++;
        if ({ack, nack, timeout_err} !== {4'b0010, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL tmo recover: ack/nack/err %b want 0010_0000_1", {ack, nack, timeout_err});
        end
        req = '0;
        drain();
    endtask

    task automatic test_reset_mid();
        v_in[15:12] = make_vote(3'b011, 1'b1); req = 4'b1000; rtr = 1'b0;
        tick();
        rtr = 1'b1;
        tick();
        checks++;
        if ({cts, v_out} !== {1'b1, 4'b0011}) begin
            errors++; $display("FAIL rstmid cts: cts/v_out %b want 1_0011", {cts, v_out});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({cts, ack, nack, busy, timeout_err} !== 11'b0) begin
            errors++;
            $display("FAIL rstmid reset: cts/ack/nack/busy/err %b want 0",
                     {cts, ack, nack, busy, timeout_err});
        end
        reset = 1'b0; req = '0; rtr = 1'b0;
        tick();
        checks++;
        if ({ack, nack, busy, cts} !== 10'b0) begin
            errors++;
            $display("FAIL rstmid after: ack/nack/busy/cts %b want 0", {ack, nack, busy, cts});
        end
        v_in[3:0] = make_vote(3'b001, 1'b1); req = 4'b0001;
        tick();
        checks++;
        if ({busy, grant_id} !== {1'b1, 2'd0}) begin
            errors++; $display("FAIL rstmid idle: busy/id %b want 1_00", {busy, grant_id});
        end
        req = '0;
        drain();
    endtask

    task automatic test_random();
        int stuck;
        reset = 1'b1; req = '0; rtr = 1'b0;
        model_edge();
        tick();
        reset = 1'b0; stuck = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && (m_ack[i] || m_nack[i])) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    v_in[4*i +: 4] = rand_vote();
                end else if ($urandom_range(0, 9) == 0) begin
                    v_in[4*i +: 4] = rand_vote();
                end
            end
            if (stuck > 0) begin
                stuck--;
            end else if ($urandom_range(0, 99) < 2) begin
                stuck = 20;
                rtr = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 2) == 0) begin
                rtr = ~rtr;
            end
            model_edge();
            tick();
            checks++;
            if ({ack, nack, cts, v_out, grant_id, busy, timeout_err} !==
                {m_ack, m_nack, m_cts, m_vout, m_gid, m_busy, m_err}) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h", c,
                         {ack, nack, cts, v_out, grant_id, busy, timeout_err},
                         {m_ack, m_nack, m_cts, m_vout, m_gid, m_busy, m_err});
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; v_in = '0; rtr = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_parity();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
